// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces one quotient bit per clock. The result is packed as
// {remainder, quotient} so it can go straight onto the HI/LO write.
module div #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    DIV_FREE,
    DIV_BY_ZERO,
    DIV_ON,
    DIV_END
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] work;
  logic [2*WIDTH:0] work_step;
  logic [WIDTH-1:0] divisor;
  logic             sign1;
  logic             sign2;
  logic             signed_r;
  logic [WIDTH:0]   upper;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             last_step;

  assign last_step = (cnt == CW'(WIDTH));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_FREE;
    else     state <= state_next;
  end

  // Next-state logic; annul wins over finalize while dividing.
  always_comb begin
    state_next = state;
    case (state)
      DIV_FREE: begin
        if (start_i && !annul_i)
          state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: state_next = DIV_END;
      DIV_ON: begin
        if (annul_i)        state_next = DIV_FREE;
        else if (last_step) state_next = DIV_END;
      end
      DIV_END: begin
        if (!start_i) state_next = DIV_FREE;
      end
      default: state_next = DIV_FREE;
    endcase
  end

  // Operand magnitudes for signed mode.
  always_comb begin
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  // One shift / trial-subtract step on the working register.
  always_comb begin
    // Upper W+1 bits of the working register after the left shift.
    upper     = work[2*WIDTH-1:WIDTH-1];
    diff      = upper - {1'b0, divisor};
    work_step = {work[2*WIDTH-1:0], 1'b0};
    if (upper >= {1'b0, divisor})
      work_step = {diff, work[WIDTH-2:0], 1'b1};
  end

  // Sign correction: quotient negated on differing signs, remainder follows dividend.
  always_comb begin
    quot = work[WIDTH-1:0];
    rem  = work[2*WIDTH-1:WIDTH];
    if (signed_r && (sign1 ^ sign2)) quot = -quot;
    if (signed_r && sign1)           rem  = -rem;
  end

  // Datapath, step counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
      work     <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      signed_r <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i && (opdata2_i != '0)) begin
            work     <= {{(WIDTH+1){1'b0}}, mag1};
            divisor  <= mag2;
            sign1    <= opdata1_i[WIDTH-1];
            sign2    <= opdata2_i[WIDTH-1];
            signed_r <= signed_div_i;
            cnt      <= '0;
          end
        end
        DIV_BY_ZERO: begin
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        DIV_ON: begin
          if (annul_i) begin
            cnt <= '0;
          end else if (last_step) begin
            result_o <= {rem, quot};
            ready_o  <= 1'b1;
          end else begin
            work <= work_step;
            cnt  <= cnt + 1'b1;
          end
        end
        DIV_END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the divider: stimulus pushes expected result and
// ready cycle; a monitor pops and compares on every rising ready_o.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned passed = 0;

  logic [63:0] exp_res_q[$];
  int unsigned exp_cyc_q[$];

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every rising ready_o must match the oldest expectation.
  logic ready_q = 1'b0;
  always @(negedge clk) begin
    if (ready_o && !ready_q) begin
      if (exp_res_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        chk("result", result_o, exp_res_q.pop_front());
        chk("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
    ready_q = ready_o;
  end

  // Issue one division, wait for ready (operands scrambled meanwhile),
  // optionally hold start in DIV_END, then drop start and check the return.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int unsigned lat,
                        input int unsigned hold);
    logic [63:0] held;
    bit          got;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 1 + lat);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = ~signed_div_i;
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    held = result_o;
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  initial begin
    int unsigned highs;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;

    do_div(1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, 33, 0);
    do_div(1'b1, 32'hFFFFFFF9,  32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33, 0);
    do_div(1'b1, 32'h00000007,  32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 0);
    do_div(1'b0, 32'd5,         32'd0,          64'h00000000_00000000, 1,  0);
    do_div(1'b1, 32'd5,         32'd0,          64'h00000000_00000000, 1,  0);

    // Annul at the 10th DIV_ON edge: no result may ever appear.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) highs++;
    end
    chk("annul_no_ready", 64'(highs), 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Reset mid-DIV_ON.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (6) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) highs++;
    end
    chk("rst_no_ready", 64'(highs), 64'd0);

    do_div(1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, 5);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
    do_div(1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_res_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU.
- Responder to the execute stage. EX raises start_i with operands, holds its stall request until ready_o, then drops start_i.
- Result is packed as {remainder, quotient}, so EX forwards it directly onto the HI/LO write request (HI = remainder, LO = quotient).
- Uses radix-2 restoring division, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width. result_o is 2*WIDTH wide; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance
- opdata1_i  input  WIDTH  dividend; sampled at start acceptance
- opdata2_i  input  WIDTH  divisor; sampled at start acceptance
- start_i  input  1  division request from EX; level, held high until ready_o is seen
- annul_i  input  1  cancel the in-flight division (branch/flush)
- result_o  output  2*WIDTH  [2W-1:W] = remainder, [W-1:0] = quotient
- ready_o  output  1  result valid

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1 at an edge: state=DIV_FREE, cnt=0, ready_o=0, result_o=0. This includes reset mid-operation.
  - Operands are registered at acceptance; later changes on the operand inputs have no effect on an in-flight division.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- DIV_FREE:
  - ready_o=0, result_o=0.
  - At an edge with start_i=1 and annul_i=0 (acceptance edge k):
    - If opdata2_i==0, go to DIV_BY_ZERO.
    - Otherwise latch |op1| and |op2| (magnitudes when signed_div_i=1 and the MSB is set, raw values otherwise), latch both sign bits and signed_div_i, set cnt=0, go to DIV_ON.
  - start_i with annul_i=1 is ignored.
- DIV_BY_ZERO: at the next edge go to DIV_END with result_o=0 and ready_o=1, i.e. ready is visible after edge k+1.
- DIV_ON:
  - Each edge performs one shift/trial-subtract step on a 2W+1-bit working register and increments cnt.
  - After WIDTH steps (edges k+1..k+32), the edge with cnt==WIDTH applies sign correction, loads result_o, sets ready_o=1 and goes to DIV_END. Ready is visible after edge k+33, i.e. fixed latency 33 cycles.
  - If annul_i=1 at any DIV_ON edge: go to DIV_FREE, cnt=0, ready_o stays 0, no result produced. Annul takes priority over the finalize step.
- Sign correction (signed only):
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned mode takes no correction.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0; no trap or flag.
- DIV_END:
  - ready_o=1 and result_o stable while start_i=1; annul_i is ignored.
  - At the first edge with start_i=0: go to DIV_FREE, ready_o=0, result_o=0.
- Handshake rules:
  - A new division requires a pass through DIV_FREE. start_i held continuously high never re-triggers from DIV_END.
  - The earliest re-acceptance is the edge after the return to DIV_FREE.

Test Plan:
- Unsigned: signed_div_i=0, 100 / 7, start at edge k -> ready_o rises after edge k+33, result_o=0x00000002_0000000E; drop start -> next edge ready_o=0, result_o=0.
- Signed, mixed signs:
  - -7 / 2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD.
  - 7 / -2 -> result_o=0x00000001_FFFFFFFD.
- Divide by zero: 5 / 0 -> ready_o high after edge k+1, result_o=0.
  - Same with signed_div_i=1 -> identical response.
- Annul mid-operation:
  - Assert annul_i for one cycle at the 10th DIV_ON edge -> ready_o never asserts, state back in DIV_FREE.
  - Then 9 / 3 unsigned -> result_o=0x00000000_00000003 after 33 cycles.
  - Also assert rst mid-DIV_ON -> outputs 0 at the next edge.
- Hold and boundaries:
  - Keep start_i high 5 cycles in DIV_END -> ready_o and result_o unchanged, no restart.
  - Unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
  - Signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000.
  - Operand inputs toggled during DIV_ON -> result unaffected.
